// File: rtl/ingress_cell_tagger.sv
// Per-port ingress tagger: parses framed 6-bit symbols, admits or drops whole frames
// at the header, and writes each payload symbol as one {payload, dest} cell.
module ingress_cell_tagger #(
  parameter int FIFO_DEPTH = 256,
  parameter int AW         = 8,
  parameter int MAX_FRAME  = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [7:0]    in_data,
  input  logic [AW-1:0] fifo_usedw,
  input  logic          fifo_full,
  output logic          wrreq,
  output logic [7:0]    wrdata,
  output logic [15:0]   frm_ok_cnt,
  output logic [15:0]   frm_drop_cnt,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam int LW = $clog2(MAX_FRAME + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   RESERVE_W = (AW+1)'(MAX_FRAME);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_FRAME);

  state_t        state_q, state_d;
  logic [1:0]    dest_q, dest_d;
  logic [LW-1:0] len_q, len_d;
  logic          wrreq_q, wrreq_d;
  logic [7:0]    wrdata_q, wrdata_d;
  logic [15:0]   ok_q, ok_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          ovf_set;

  logic [AW:0] free_space;
  logic        hdr;
  logic        admit;
  logic        unused_bits;

  // Free space is computed one bit wider so an empty FIFO reports the full depth.
  assign free_space  = DEPTH_W - {1'b0, fifo_usedw};
  assign hdr         = in_valid & in_sop;
  assign admit       = (in_data[1:0] != 2'b00) && (free_space >= RESERVE_W) && !fifo_full;
  assign unused_bits = ^in_data[7:6];

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    wrreq_d  = 1'b0;
    wrdata_d = wrdata_q;
    ok_d     = ok_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    ovf_set  = 1'b0;

    if (hdr) begin
      // A header in any state silently terminates whatever frame was open.
      if (admit) begin
        dest_d  = in_data[1:0];
        len_d   = '0;
        ok_d    = (ok_q == 16'hFFFF) ? ok_q : ok_q + 16'd1;
        state_d = FWD;
      end else begin
        drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        state_d = DROP;
      end
      if (in_eop) state_d = IDLE;
    end else if (in_valid) begin
      case (state_q)
        FWD: begin
          if ((len_q < LEN_MAX) && !fifo_full) begin
            wrreq_d  = 1'b1;
            wrdata_d = {in_data[5:0], dest_q};
            len_d    = len_q + 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
          if (in_eop) state_d = IDLE;
        end
        DROP: begin
          if (in_eop) state_d = IDLE;
        end
        default: ;
      endcase
    end

    if (ovf_clr)      ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dest_q   <= 2'b00;
      len_q    <= '0;
      wrreq_q  <= 1'b0;
      wrdata_q <= 8'h00;
      ok_q     <= 16'h0000;
      drop_q   <= 16'h0000;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      wrreq_q  <= wrreq_d;
      wrdata_q <= wrdata_d;
      ok_q     <= ok_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wrreq        = wrreq_q;
  assign wrdata       = wrdata_q;
  assign frm_ok_cnt   = ok_q;
  assign frm_drop_cnt = drop_q;
  assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_ingress_cell_tagger.sv
// Directed bench for ingress_cell_tagger: a vector table for single-cycle behaviour
// plus hand-written sequences for truncation, overflow clear and mid-frame reset.
module tb_ingress_cell_tagger;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  fifo_usedw = 8'h00;
  logic        fifo_full = 1'b0;
  logic        wrreq;
  logic [7:0]  wrdata;
  logic [15:0] frm_ok_cnt, frm_drop_cnt;
  logic        ovf_sticky;
  logic        ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ingress_cell_tagger #(.FIFO_DEPTH(256), .AW(8), .MAX_FRAME(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
    .wrreq(wrreq), .wrdata(wrdata),
    .frm_ok_cnt(frm_ok_cnt), .frm_drop_cnt(frm_drop_cnt),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, s, e;
    logic [7:0] d;
    logic [7:0] uw;
    logic       f;
    logic       exp_wr;
    logic [7:0] exp_data;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, s, e, input logic [7:0] d, uw, input logic f,
                     input logic exp_wr, input logic [7:0] exp_data, input string name);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.d = d; t.uw = uw; t.f = f;
    t.exp_wr = exp_wr; t.exp_data = exp_data; t.name = name;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one symbol, clocks it in, and leaves time at #1 past the edge for sampling.
  task automatic drive(input logic v, s, e, input logic [7:0] d, uw, input logic f);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; fifo_usedw = uw; fifo_full = f;
    @(posedge clk);
    #1;
    $display("t=%0t v=%b sop=%b eop=%b d=%h usedw=%0d full=%b -> wrreq=%b wrdata=%h",
             $time, v, s, e, d, uw, f, wrreq, wrdata);
  endtask

  initial begin
    int writes;

    // Test 1: basic frame, dest=10
    add(1,1,0,8'h02,8'd0,0, 0,8'h00,"t1_hdr");
    add(1,0,0,8'h15,8'd0,0, 1,8'h56,"t1_p0");
    add(1,0,0,8'h2A,8'd0,0, 1,8'hAA,"t1_p1");
    add(1,0,1,8'h3F,8'd0,0, 1,8'hFE,"t1_p2");
    add(1,0,0,8'h3F,8'd0,0, 0,8'h00,"idle_ignore");
    add(0,0,0,8'h00,8'd0,0, 0,8'h00,"idle_gap");
    // Test 2: dest=00 dropped
    add(1,1,0,8'h00,8'd0,0, 0,8'h00,"t2_hdr");
    add(1,0,0,8'h01,8'd0,0, 0,8'h00,"t2_p0");
    add(1,0,0,8'h02,8'd0,0, 0,8'h00,"t2_p1");
    add(1,0,0,8'h03,8'd0,0, 0,8'h00,"t2_p2");
    add(1,0,1,8'h04,8'd0,0, 0,8'h00,"t2_p3");
    add(1,0,0,8'h05,8'd0,0, 0,8'h00,"t2_idle");
    // Test 3: admission threshold on free space
    add(1,1,0,8'h01,8'd193,0, 0,8'h00,"t3_hdr193");
    add(1,0,0,8'h01,8'd193,0, 0,8'h00,"t3_drop_p0");
    add(1,0,1,8'h02,8'd193,0, 0,8'h00,"t3_drop_p1");
    add(1,1,0,8'h01,8'd192,0, 0,8'h00,"t3_hdr192");
    add(1,0,0,8'h01,8'd192,0, 1,8'h05,"t3_ok_p0");
    add(1,0,1,8'h02,8'd192,0, 1,8'h09,"t3_ok_p1");
    // Test 5: sop mid-frame switches destination
    add(1,1,0,8'h01,8'd0,0, 0,8'h00,"t5_hdr_a");
    add(1,0,0,8'h10,8'd0,0, 1,8'h41,"t5_a0");
    add(1,0,0,8'h11,8'd0,0, 1,8'h45,"t5_a1");
    add(1,1,0,8'h02,8'd0,0, 0,8'h00,"t5_hdr_b");
    add(1,0,0,8'h12,8'd0,0, 1,8'h4A,"t5_b0");
    add(1,0,1,8'h13,8'd0,0, 1,8'h4E,"t5_b1");
    // Header-only frame (sop+eop) is counted, then FSM is idle
    add(1,1,1,8'h01,8'd0,0, 0,8'h00,"hdr_eop");
    add(1,0,0,8'h3F,8'd0,0, 0,8'h00,"hdr_eop_idle");
    // Test 6a: one-cycle fifo_full skips a symbol
    add(1,1,0,8'h01,8'd0,0, 0,8'h00,"t6_hdr");
    add(1,0,0,8'h01,8'd0,0, 1,8'h05,"t6_p0");
    add(1,0,0,8'h02,8'd0,1, 0,8'h00,"t6_full");
    add(1,0,1,8'h03,8'd0,0, 1,8'h0D,"t6_p2");

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrreq", 16'(wrreq), 16'h0);
    chk("rst_wrdata", 16'(wrdata), 16'h0);
    chk("rst_ok", frm_ok_cnt, 16'h0);
    chk("rst_drop", frm_drop_cnt, 16'h0);
    chk("rst_ovf", 16'(ovf_sticky), 16'h0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].uw, tbl[i].f);
      chk({tbl[i].name, "_wrreq"}, 16'(wrreq), 16'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) chk({tbl[i].name, "_wrdata"}, 16'(wrdata), 16'(tbl[i].exp_data));
    end
    drive(0,0,0,8'h00,8'd0,0);

    // Admitted: t1, t3(192), t5 x2, hdr_eop, t6 = 6; dropped: t2, t3(193) = 2
    chk("tbl_ok_cnt", frm_ok_cnt, 16'd6);
    chk("tbl_drop_cnt", frm_drop_cnt, 16'd2);
    chk("full_ovf_set", 16'(ovf_sticky), 16'h1);
    ovf_clr = 1'b1;
    drive(0,0,0,8'h00,8'd0,0);
    ovf_clr = 1'b0;
    chk("ovf_clr", 16'(ovf_sticky), 16'h0);

    // Test 4: 70-symbol frame truncated at 64 writes; clear wins over a set
    writes = 0;
    drive(1,1,0,8'h03,8'd0,0);
    for (int i = 0; i < 70; i++) begin
      ovf_clr = (i == 64);
      drive(1,0,(i == 69),{2'b00, 6'(i)},8'd0,0);
      chk($sformatf("t4_wrreq_%0d", i), 16'(wrreq), 16'(i < 64));
      if (wrreq) begin
        writes++;
        chk($sformatf("t4_wrdata_%0d", i), 16'(wrdata), 16'({6'(i), 2'b11}));
      end
      if (i == 63) chk("t4_ovf_before_trunc", 16'(ovf_sticky), 16'h0);
      if (i == 64) chk("t4_clr_priority", 16'(ovf_sticky), 16'h0);
      if (i == 65) chk("t4_ovf_trunc", 16'(ovf_sticky), 16'h1);
    end
    ovf_clr = 1'b0;
    chk("t4_write_count", 16'(writes), 16'd64);
    chk("t4_ok_cnt", frm_ok_cnt, 16'd7);
    ovf_clr = 1'b1;
    drive(0,0,0,8'h00,8'd0,0);
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared", 16'(ovf_sticky), 16'h0);

    // Test 6b: async reset mid-frame
    drive(1,1,0,8'h02,8'd0,0);
    drive(1,0,0,8'h01,8'd0,0);
    chk("t6b_pre_rst_wrreq", 16'(wrreq), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6b_rst_wrreq", 16'(wrreq), 16'h0);
    chk("t6b_rst_ok", frm_ok_cnt, 16'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1,0,(i == 3),8'h07,8'd0,0);
      chk($sformatf("t6b_ignored_%0d", i), 16'(wrreq), 16'h0);
    end
    drive(1,1,0,8'h03,8'd0,0);
    drive(1,0,1,8'h20,8'd0,0);
    chk("t6b_resume_wrreq", 16'(wrreq), 16'h1);
    chk("t6b_resume_wrdata", 16'(wrdata), 16'h83);
    chk("t6b_resume_ok", frm_ok_cnt, 16'd1);
    drive(0,0,0,8'h00,8'd0,0);
    chk("t6b_single_pulse", 16'(wrreq), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
